// File: rtl/frame_streamer_if.sv
// ---------------------------------------------------------------------------
// frame_streamer_if
// AXI4-Stream video bundle that frame_streamer drives.
//   tdata  : {8'h00, RGB} pixel
//   tvalid : pixel on tdata is valid
//   tready : sink accepts the pixel on this clock edge
//   tlast  : last pixel of a line
//   tuser  : first pixel of a frame
// Modports: master (the streamer), slave (the video sink).
// ---------------------------------------------------------------------------
interface frame_streamer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    modport master (
        output tdata,
        output tvalid,
        input  tready,
        output tlast,
        output tuser
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready,
        input  tlast,
        input  tuser
    );
endinterface

// File: rtl/frame_streamer.sv
// ---------------------------------------------------------------------------
// frame_streamer
// Reads the cell grid back from BRAM one row per word, in row order. Each
// cell bit becomes one RGB pixel on an AXI4-Stream video output.
// Ports:
//   out_stream_aclk : clock for the BRAM read port and the stream
//   rst             : asynchronous reset, active high
//   enable          : stream frames back to back while high
//   read_addr       : BRAM read address (row index)
//   read_en         : BRAM read strobe
//   read_mem        : BRAM read data, bit x = cell x, valid 1 cycle after read_en
//   out_stream      : AXI4-Stream master (tuser = start of frame, tlast = end of line)
//   frame_done      : 1-cycle pulse after the last pixel of a frame is accepted
//   busy            : high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module frame_streamer #(
    parameter int          COLS      = 1280,
    parameter int          ROWS      = 720,
    parameter int          ADDR_W    = 10,
    parameter logic [23:0] ALIVE_RGB = 24'hFFFFFF,
    parameter logic [23:0] DEAD_RGB  = 24'h000000
) (
    input  logic                  out_stream_aclk,
    input  logic                  rst,
    input  logic                  enable,
    output logic [ADDR_W-1:0]     read_addr,
    output logic                  read_en,
    input  logic [COLS-1:0]       read_mem,
    frame_streamer_if.master      out_stream,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int                COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRIME  = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] row_q,       row_d;
    logic [COL_W-1:0]  col_q,       col_d;
    logic [COLS-1:0]   cur_row_q,   cur_row_d;
    logic [COLS-1:0]   nxt_row_q,   nxt_row_d;
    logic              cap_q,       cap_d;
    logic              read_en_q,   read_en_d;
    logic [ADDR_W-1:0] read_addr_q, read_addr_d;
    logic [31:0]       tdata_q,     tdata_d;
    logic              tvalid_q,    tvalid_d;
    logic              tlast_q,     tlast_d;
    logic              tuser_q,     tuser_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q,      busy_d;
    logic              hs_s;

    // Expand one cell bit of a row word into a 32-bit stream pixel.
    function automatic logic [31:0] pixel_f(input logic [COLS-1:0] bits,
                                            input logic [COL_W-1:0] idx);
        return {8'h00, (bits[idx] ? ALIVE_RGB : DEAD_RGB)};
    endfunction

    assign hs_s = tvalid_q & out_stream.tready;

    // Next-state and next-output logic for the read/stream FSM.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        cur_row_d    = cur_row_q;
        read_en_d    = 1'b0;
        read_addr_d  = read_addr_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        frame_done_d = 1'b0;
        // A prefetch strobe seen in STREAM means read_mem holds the next row now.
        cap_d        = read_en_q && (state_q == ST_STREAM);
        // Bypass so a row end on the capture edge still picks up fresh data.
        nxt_row_d    = cap_q ? read_mem : nxt_row_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d     = ST_PRIME;
                    read_en_d   = 1'b1;
                    read_addr_d = {ADDR_W{1'b0}};
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_PRIME: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cur_row_d = read_mem;
                tvalid_d  = 1'b1;
                tuser_d   = 1'b1;
                tdata_d   = pixel_f(read_mem, {COL_W{1'b0}});
                tlast_d   = 1'b0;
                col_d     = {COL_W{1'b0}};
                row_d     = {ADDR_W{1'b0}};
                state_d   = ST_STREAM;
            end
            ST_STREAM: begin
                if (hs_s) begin
                    tuser_d = 1'b0;
                    // Fetch row r+1 while row r is still being sent.
                    if ((col_q == {COL_W{1'b0}}) && (row_q != ROW_LAST)) begin
                        read_en_d   = 1'b1;
                        read_addr_d = row_q + ADDR_W'(1);
                    end else begin
                        read_en_d   = 1'b0;
                    end
                    if (col_q == COL_LAST) begin
                        col_d = {COL_W{1'b0}};
                        if (row_q == ROW_LAST) begin
                            frame_done_d = 1'b1;
                            tvalid_d     = 1'b0;
                            tlast_d      = 1'b0;
                            tdata_d      = 32'h0000_0000;
                            row_d        = {ADDR_W{1'b0}};
                            if (enable) begin
                                state_d     = ST_PRIME;
                                read_en_d   = 1'b1;
                                read_addr_d = {ADDR_W{1'b0}};
                            end else begin
                                state_d     = ST_IDLE;
                            end
                        end else begin
                            cur_row_d = nxt_row_d;
                            row_d     = row_q + ADDR_W'(1);
                            tdata_d   = pixel_f(nxt_row_d, {COL_W{1'b0}});
                            tlast_d   = 1'b0;
                        end
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        tdata_d = pixel_f(cur_row_q, col_q + COL_W'(1));
                        tlast_d = ((col_q + COL_W'(1)) == COL_LAST);
                    end
                end else begin
                    // Stalled: every stream output holds its value.
                    state_d = ST_STREAM;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge out_stream_aclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= {ADDR_W{1'b0}};
            col_q        <= {COL_W{1'b0}};
            cur_row_q    <= {COLS{1'b0}};
            nxt_row_q    <= {COLS{1'b0}};
            cap_q        <= 1'b0;
            read_en_q    <= 1'b0;
            read_addr_q  <= {ADDR_W{1'b0}};
            tdata_q      <= 32'h0000_0000;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cur_row_q    <= cur_row_d;
            nxt_row_q    <= nxt_row_d;
            cap_q        <= cap_d;
            read_en_q    <= read_en_d;
            read_addr_q  <= read_addr_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign read_en           = read_en_q;
    assign read_addr         = read_addr_q;
    assign out_stream.tdata  = tdata_q;
    assign out_stream.tvalid = tvalid_q;
    assign out_stream.tlast  = tlast_q;
    assign out_stream.tuser  = tuser_q;
    assign frame_done        = frame_done_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_frame_streamer
// Directed bench for frame_streamer with an 8x4 grid and a 1-cycle BRAM.
// ---------------------------------------------------------------------------
module tb_frame_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] read_addr;
    logic       read_en;
    logic [7:0] read_mem = 8'h00;
    logic       frame_done;
    logic       busy;

    frame_streamer_if ifc ();

    frame_streamer #(
        .COLS   (8),
        .ROWS   (4),
        .ADDR_W (2)
    ) dut (
        .out_stream_aclk (clk),
        .rst             (rst),
        .enable          (enable),
        .read_addr       (read_addr),
        .read_en         (read_en),
        .read_mem        (read_mem),
        .out_stream      (ifc),
        .frame_done      (frame_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [4];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stall_viol = 0;
    int re_double = 0;
    logic re_prev = 1'b0;
    logic hold_pend = 1'b0;
    logic [34:0] hold_val = 35'd0;

    logic [31:0] beat_data [$];
    logic        beat_last [$];
    logic        beat_user [$];
    int          beat_cyc  [$];
    int          fd_cyc    [$];
    logic [1:0]  raddr_q   [$];

    // BRAM model: registered read, 1-cycle latency.
    always @(posedge clk) begin
        if (read_en) read_mem <= mem[read_addr];
    end

    // Bus monitor: logs beats, read strobes, frame_done, and stall stability.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        re_prev <= read_en;
        if (read_en && re_prev) re_double <= re_double + 1;
        if (read_en) raddr_q.push_back(read_addr);
        if (frame_done) fd_cyc.push_back(cyc);
        if (ifc.tvalid && ifc.tready) begin
            beat_data.push_back(ifc.tdata);
            beat_last.push_back(ifc.tlast);
            beat_user.push_back(ifc.tuser);
            beat_cyc.push_back(cyc);
        end
        if (hold_pend && !rst &&
            ({ifc.tvalid, ifc.tdata, ifc.tlast, ifc.tuser} != hold_val))
            stall_viol <= stall_viol + 1;
        hold_pend <= ifc.tvalid && !ifc.tready && !rst;
        hold_val  <= {1'b1, ifc.tdata, ifc.tlast, ifc.tuser};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int b;
        b = budget;
        while (beat_data.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("beats_reached", 64'(beat_data.size() >= n), 64'd1);
    endtask

    task automatic clear_logs();
        beat_data.delete();
        beat_last.delete();
        beat_user.delete();
        beat_cyc.delete();
        fd_cyc.delete();
        raddr_q.delete();
    endtask

    // Expected pixel for beat index b of a frame (row-major, 8 pixels per row).
    function automatic logic [31:0] exp_pix(input int b);
        logic [7:0] r;
        r = mem[(b / 8) % 4];
        return r[b % 8] ? 32'h00FF_FFFF : 32'h0000_0000;
    endfunction

    task automatic check_frame(input string tag, input int base);
        for (int b = 0; b < 32; b++) begin
            check($sformatf("%s_beat%0d", tag, b),
                  {30'd0, beat_user[base+b], beat_last[base+b], beat_data[base+b]},
                  {30'd0, 1'(b == 0), 1'(b % 8 == 7), exp_pix(b)});
        end
    endtask

    function automatic logic [63:0] outs_now();
        return {24'd0, ifc.tdata, 2'd0, read_addr,
                ifc.tvalid, ifc.tlast, ifc.tuser, read_en, frame_done, busy};
    endfunction

    initial begin
        int en_cyc;
        int budget;
        mem[0] = 8'b0000_0101;
        mem[1] = 8'b1000_0001;
        mem[2] = 8'b1111_0000;
        mem[3] = 8'b0011_1100;
        rst = 1'b1;
        enable = 1'b0;
        ifc.tready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_now(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", outs_now(), 64'd0);

        // Cases 1 and 2: one frame with tready held high.
        clear_logs();
        enable = 1'b1;
        ifc.tready = 1'b1;
        en_cyc = cyc;
        @(negedge clk);
        enable = 1'b0;
        wait_beats(32, 100);
        repeat (4) @(negedge clk);
        check("first_beat_latency", 64'(beat_cyc[0]), 64'(en_cyc + 3));
        check_frame("f1", 0);
        check("no_line_gaps", 64'(beat_cyc[31] - beat_cyc[0]), 64'd31);
        check("frame_done_count", 64'(fd_cyc.size()), 64'd1);
        check("frame_done_timing", 64'(fd_cyc[0]), 64'(beat_cyc[31] + 1));
        check("read_count", 64'(raddr_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("read_addr%0d", i), 64'(raddr_q[i]), 64'(i));
        check("idle_after_frame", {62'd0, busy, ifc.tvalid}, 64'd0);

        // Case 3: random backpressure must not alter the pixel sequence.
        clear_logs();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        budget = 600;
        while (beat_data.size() < 32 && budget > 0) begin
            ifc.tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            budget--;
        end
        check("rand_beats_reached", 64'(beat_data.size()), 64'd32);
        ifc.tready = 1'b1;
        repeat (4) @(negedge clk);
        check_frame("rand", 0);
        check("stall_stability", 64'(stall_viol), 64'd0);

        // Case 4: enable held for two frames.
        clear_logs();
        enable = 1'b1;
        budget = 200;
        while (beat_data.size() < 33 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        enable = 1'b0;
        wait_beats(64, 100);
        repeat (4) @(negedge clk);
        // Next frame's first beat lands on the third cycle after the final beat.
        check("frame_gap", 64'(beat_cyc[32] - beat_cyc[31]), 64'd3);
        check_frame("f2a", 0);
        check_frame("f2b", 32);
        check("f2b_contiguous", 64'(beat_cyc[63] - beat_cyc[32]), 64'd31);
        check("two_frame_done", 64'(fd_cyc.size()), 64'd2);
        check("two_frame_beats", 64'(beat_data.size()), 64'd64);

        // Case 5: enable dropped mid-frame; the frame still completes.
        clear_logs();
        enable = 1'b1;
        budget = 100;
        while (beat_data.size() < 10 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        enable = 1'b0;
        wait_beats(32, 100);
        repeat (10) @(negedge clk);
        check("drop_beats", 64'(beat_data.size()), 64'd32);
        check_frame("drop", 0);
        check("drop_idle", {62'd0, busy, ifc.tvalid}, 64'd0);

        // Case 6: reset mid-frame, then restart from row 0.
        clear_logs();
        enable = 1'b1;
        budget = 100;
        while (beat_data.size() < 13 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        rst = 1'b1;
        #1;
        check("rst_midframe_outputs", outs_now(), 64'd0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_beats(32, 100);
        repeat (4) @(negedge clk);
        check("restart_first_addr", 64'(raddr_q[0]), 64'd0);
        check_frame("restart", 0);
        check("read_en_never_double", 64'(re_double), 64'd0);
        check("final_stall_stability", 64'(stall_viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
